// File: rtl/hamm_fifo_rx.sv
// hamm_fifo_rx: buffers 38-bit Hamming-protected words from the encoder in a
// small synchronous FIFO, and on each pop applies single-error correction and
// presents the corrected 32-bit payload with error flags and a saturating
// error counter. All status and data outputs are registered.
module hamm_fifo_rx #(
  parameter int DEPTH     = 8,
  parameter int AW        = 3,
  parameter int Nbits_32  = 32,
  parameter int Nbits_ham = 38
) (
  input  logic                 CLK,
  input  logic                 reset,
  input  logic [Nbits_ham-1:0] data_ham_in,
  input  logic                 start_write,
  input  logic                 read_req,
  output logic [Nbits_32-1:0]  data_out,
  output logic                 data_valid,
  output logic                 sec_err,
  output logic                 ded_err,
  output logic [7:0]           err_count,
  output logic                 full,
  output logic                 empty,
  output logic [AW:0]          level,
  output logic                 overflow
);

  localparam logic [AW:0]          PTR_ONE   = {{AW{1'b0}}, 1'b1};
  localparam logic [Nbits_ham-1:0] BIT0_MASK = {{(Nbits_ham-1){1'b0}}, 1'b1};
  localparam logic [5:0]           SYN_MAX   = 6'(Nbits_ham);

  // Syndrome bit k is the XOR of every codeword bit whose Hamming position
  // (index + 1) has bit k set; a clean codeword yields zero.
  function automatic logic [5:0] f_syndrome(input logic [Nbits_ham-1:0] w);
    logic [5:0] s;
    logic [5:0] pos;
    s = 6'd0;
    for (int i = 0; i < Nbits_ham; i++) begin
      pos = 6'(i + 1);
      for (int k = 0; k < 6; k++) begin
        s[k] = s[k] ^ (w[i] & pos[k]);
      end
    end
    return s;
  endfunction

  // Gather the payload from the non-power-of-two positions, d0 in the LSB.
  function automatic logic [Nbits_32-1:0] f_extract(input logic [Nbits_ham-1:0] w);
    return {w[37:32], w[30:16], w[14:8], w[6:4], w[2]};
  endfunction

  // Storage and pointers (extra wrap bit distinguishes full from empty)
  logic [Nbits_ham-1:0] r_mem [DEPTH];
  logic [AW:0]          r_wr_ptr;
  logic [AW:0]          r_rd_ptr;
  logic [AW:0]          r_level;
  logic                 r_full;
  logic                 r_empty;
  logic                 r_overflow;

  // Output registers
  logic [Nbits_32-1:0]  r_data_out;
  logic                 r_data_valid;
  logic                 r_sec_err;
  logic                 r_ded_err;
  logic [7:0]           r_err_count;

  // Combinational helpers
  logic                 w_wr_en;
  logic                 w_rd_en;
  logic [AW:0]          w_wr_ptr_nxt;
  logic [AW:0]          w_rd_ptr_nxt;
  logic [Nbits_ham-1:0] w_rd_word;
  logic [5:0]           w_syn;
  logic [Nbits_ham-1:0] w_corrected;
  logic                 w_sec;
  logic                 w_ded;
  logic [Nbits_32-1:0]  w_payload;

  // Accept decisions use the registered (pre-edge) full/empty flags, so a
  // write into a full FIFO is dropped even if a read frees a slot this cycle.
  always_comb begin
    w_wr_en      = start_write & ~r_full;
    w_rd_en      = read_req & ~r_empty;
    w_wr_ptr_nxt = r_wr_ptr;
    w_rd_ptr_nxt = r_rd_ptr;
    if (w_wr_en) begin
      w_wr_ptr_nxt = r_wr_ptr + PTR_ONE;
    end else begin
      w_wr_ptr_nxt = r_wr_ptr;
    end
    if (w_rd_en) begin
      w_rd_ptr_nxt = r_rd_ptr + PTR_ONE;
    end else begin
      w_rd_ptr_nxt = r_rd_ptr;
    end
  end

  // Decode the word at the head of the FIFO: correct a single error if the
  // syndrome names a valid position, otherwise flag it as uncorrectable.
  always_comb begin
    w_rd_word   = r_mem[r_rd_ptr[AW-1:0]];
    w_syn       = f_syndrome(w_rd_word);
    w_corrected = w_rd_word;
    w_sec       = 1'b0;
    w_ded       = 1'b0;
    if (w_syn == 6'd0) begin
      w_corrected = w_rd_word;
      w_sec       = 1'b0;
      w_ded       = 1'b0;
    end else if (w_syn <= SYN_MAX) begin
      w_corrected = w_rd_word ^ (BIT0_MASK << (w_syn - 6'd1));
      w_sec       = 1'b1;
      w_ded       = 1'b0;
    end else begin
      w_corrected = w_rd_word;
      w_sec       = 1'b0;
      w_ded       = 1'b1;
    end
    w_payload = f_extract(w_corrected);
  end

  // Memory array is not reset; only written on an accepted write.
  always_ff @(posedge CLK) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr[AW-1:0]] <= data_ham_in;
    end
  end

  // Pointers and status flags derived from the post-edge pointer values.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_wr_ptr   <= {(AW+1){1'b0}};
      r_rd_ptr   <= {(AW+1){1'b0}};
      r_level    <= {(AW+1){1'b0}};
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_overflow <= 1'b0;
    end else begin
      r_wr_ptr   <= w_wr_ptr_nxt;
      r_rd_ptr   <= w_rd_ptr_nxt;
      r_level    <= w_wr_ptr_nxt - w_rd_ptr_nxt;
      r_full     <= (w_wr_ptr_nxt[AW-1:0] == w_rd_ptr_nxt[AW-1:0]) &&
                    (w_wr_ptr_nxt[AW] != w_rd_ptr_nxt[AW]);
      r_empty    <= (w_wr_ptr_nxt == w_rd_ptr_nxt);
      r_overflow <= r_overflow | (start_write & r_full);
    end
  end

  // Registered read results: one-cycle valid pulse per pop, payload held
  // between pops, flags cleared on idle cycles.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_data_out   <= {Nbits_32{1'b0}};
      r_data_valid <= 1'b0;
      r_sec_err    <= 1'b0;
      r_ded_err    <= 1'b0;
    end else begin
      r_data_valid <= w_rd_en;
      r_sec_err    <= w_rd_en & w_sec;
      r_ded_err    <= w_rd_en & w_ded;
      if (w_rd_en) begin
        r_data_out <= w_payload;
      end
    end
  end

  // Saturating count of popped words that carried any detected error.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_err_count <= 8'd0;
    end else if (w_rd_en && (w_sec || w_ded) && (r_err_count != 8'hFF)) begin
      r_err_count <= r_err_count + 8'd1;
    end
  end

  assign data_out   = r_data_out;
  assign data_valid = r_data_valid;
  assign sec_err    = r_sec_err;
  assign ded_err    = r_ded_err;
  assign err_count  = r_err_count;
  assign full       = r_full;
  assign empty      = r_empty;
  assign level      = r_level;
  assign overflow   = r_overflow;

endmodule
